// File: rtl/uart_frame_parser_if.sv
// Byte-stream interface of the UART frame parser: receiver side in, payload stream and status out.
interface uart_frame_parser_if;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       out_start;
    logic [7:0] out_data;
    logic       out_valid;
    logic       out_last;
    logic       out_ready;
    logic       out_abort;
    logic       frame_ok;
    logic       frame_err;
    logic [2:0] err_code;
    logic       busy;

    // Environment side: feeds receiver bytes and downstream backpressure.
    modport master (
        output rx_data, rx_valid, out_ready,
        input  out_start, out_data, out_valid, out_last, out_abort,
        input  frame_ok, frame_err, err_code, busy
    );

    // Parser side.
    modport slave (
        input  rx_data, rx_valid, out_ready,
        output out_start, out_data, out_valid, out_last, out_abort,
        output frame_ok, frame_err, err_code, busy
    );
endinterface

// File: rtl/uart_frame_parser.sv
// Parses SOF/LEN/payload/XOR-checksum frames from a UART byte stream and queues
// the payload in a small FIFO for a downstream hash core.
module uart_frame_parser #(
    parameter int unsigned FIFO_DEPTH = 8,
    parameter int unsigned MAX_LEN    = 1024,
    parameter int unsigned TIMEOUT    = 500000
) (
    input  logic                clk,
    input  logic                rst,
    uart_frame_parser_if.slave  bus
);
    localparam int unsigned AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int unsigned CW = AW + 1;
    localparam int unsigned TW = $clog2(TIMEOUT + 1);

    localparam logic [7:0] SOF     = 8'h01;
    localparam logic [2:0] ERR_LEN = 3'd1;
    localparam logic [2:0] ERR_OVF = 3'd2;
    localparam logic [2:0] ERR_CHK = 3'd3;
    localparam logic [2:0] ERR_TMO = 3'd4;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LEN_HI,
        ST_LEN_LO,
        ST_PAYLOAD,
        ST_CHECK
    } state_t;

    state_t        state_q, state_d;
    logic [15:0]   len_q, len_d;
    logic [15:0]   rem_q, rem_d;
    logic [7:0]    chk_q, chk_d;
    logic [TW-1:0] tmo_q, tmo_d;

    logic          out_start_q, out_start_d;
    logic          out_abort_q, out_abort_d;
    logic          frame_ok_q, frame_ok_d;
    logic          frame_err_q, frame_err_d;
    logic [2:0]    err_code_q, err_code_d;
    logic          busy_q, busy_d;

    logic [8:0]    mem [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr_q, rd_ptr_q;
    logic [CW-1:0] cnt_q;

    logic          fifo_empty_c, fifo_full_c, pop_c, push_c, flush_c;
    logic          tmo_hit_c, len_bad_c;
    logic [15:0]   len_full_c;
    logic [8:0]    head_c;

    assign fifo_empty_c = (cnt_q == '0);
    assign fifo_full_c  = (cnt_q == CW'(FIFO_DEPTH));
    assign pop_c        = !fifo_empty_c && bus.out_ready;
    assign head_c       = mem[rd_ptr_q];

    // Low byte of len_q is zero after LEN_HI, so OR-ing in rx_data forms the full length.
    assign len_full_c = len_q | {8'h00, bus.rx_data};
    assign len_bad_c  = (len_full_c == 16'd0) || (32'(len_full_c) > MAX_LEN);
    assign tmo_hit_c  = (state_q != ST_IDLE) && !bus.rx_valid && (tmo_q == TW'(TIMEOUT - 1));

    // Next-state, datapath and status-pulse decode.
    always_comb begin
        state_d     = state_q;
        len_d       = len_q;
        rem_d       = rem_q;
        chk_d       = chk_q;
        tmo_d       = (state_q == ST_IDLE || bus.rx_valid) ? '0 : tmo_q + TW'(1);
        out_start_d = 1'b0;
        out_abort_d = 1'b0;
        frame_ok_d  = 1'b0;
        frame_err_d = 1'b0;
        err_code_d  = err_code_q;
        push_c      = 1'b0;
        flush_c     = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                if (bus.rx_valid && bus.rx_data == SOF) begin
                    state_d = ST_LEN_HI;
                end
            end
            ST_LEN_HI: begin
                if (bus.rx_valid) begin
                    len_d   = {bus.rx_data, 8'h00};
                    state_d = ST_LEN_LO;
                end
            end
            ST_LEN_LO: begin
                if (bus.rx_valid) begin
                    len_d = len_full_c;
                    if (len_bad_c) begin
                        frame_err_d = 1'b1;
                        err_code_d  = ERR_LEN;
                        state_d     = ST_IDLE;
                    end else begin
                        rem_d       = len_full_c;
                        chk_d       = '0;
                        out_start_d = 1'b1;
                        state_d     = ST_PAYLOAD;
                    end
                end
            end
            ST_PAYLOAD: begin
                if (bus.rx_valid) begin
                    if (fifo_full_c && !pop_c) begin
                        frame_err_d = 1'b1;
                        err_code_d  = ERR_OVF;
                        out_abort_d = 1'b1;
                        flush_c     = 1'b1;
                        state_d     = ST_IDLE;
                    end else begin
                        push_c = 1'b1;
                        chk_d  = chk_q ^ bus.rx_data;
                        rem_d  = (rem_q != 16'd0) ? rem_q - 16'd1 : 16'd0;
                        if (rem_q == 16'd1) begin
                            state_d = ST_CHECK;
                        end
                    end
                end
            end
            ST_CHECK: begin
                if (bus.rx_valid) begin
                    if (bus.rx_data == chk_q) begin
                        frame_ok_d = 1'b1;
                    end else begin
                        frame_err_d = 1'b1;
                        err_code_d  = ERR_CHK;
                        out_abort_d = 1'b1;
                    end
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // Inter-byte silence inside a frame voids it; queued payload is only dropped mid-payload.
        if (tmo_hit_c) begin
            state_d     = ST_IDLE;
            frame_err_d = 1'b1;
            err_code_d  = ERR_TMO;
            tmo_d       = '0;
            if (state_q == ST_PAYLOAD) begin
                out_abort_d = 1'b1;
                flush_c     = 1'b1;
            end
        end

        busy_d = (state_d != ST_IDLE);
    end

    // FSM state, frame registers and registered status outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            len_q       <= '0;
            rem_q       <= '0;
            chk_q       <= '0;
            tmo_q       <= '0;
            out_start_q <= 1'b0;
            out_abort_q <= 1'b0;
            frame_ok_q  <= 1'b0;
            frame_err_q <= 1'b0;
            err_code_q  <= '0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            len_q       <= len_d;
            rem_q       <= rem_d;
            chk_q       <= chk_d;
            tmo_q       <= tmo_d;
            out_start_q <= out_start_d;
            out_abort_q <= out_abort_d;
            frame_ok_q  <= frame_ok_d;
            frame_err_q <= frame_err_d;
            err_code_q  <= err_code_d;
            busy_q      <= busy_d;
        end
    end

    // FIFO pointers and occupancy; a flush empties the queue outright.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
        end else if (flush_c) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
        end else begin
            if (push_c) begin
                wr_ptr_q <= wr_ptr_q + AW'(1);
            end
            if (pop_c) begin
                rd_ptr_q <= rd_ptr_q + AW'(1);
            end
            cnt_q <= cnt_q + CW'(push_c) - CW'(pop_c);
        end
    end

    // FIFO storage: {last flag, payload byte}.
    always_ff @(posedge clk) begin
        if (push_c) begin
            mem[wr_ptr_q] <= {(rem_q == 16'd1), bus.rx_data};
        end
    end

    assign bus.out_valid = !fifo_empty_c;
    assign bus.out_data  = fifo_empty_c ? 8'h00 : head_c[7:0];
    assign bus.out_last  = !fifo_empty_c && head_c[8];
    assign bus.out_start = out_start_q;
    assign bus.out_abort = out_abort_q;
    assign bus.frame_ok  = frame_ok_q;
    assign bus.frame_err = frame_err_q;
    assign bus.err_code  = err_code_q;
    assign bus.busy      = busy_q;
endmodule

// File: doc/uart_frame_parser.md
UART_FRAME_PARSER -- requirements
Module: uart_frame_parser

Interface
REQ-001 SHALL have parameter FIFO_DEPTH, default 8, payload buffer entries (power of 2, >=2).
REQ-002 SHALL have parameter MAX_LEN, default 1024, largest legal payload length in bytes.
REQ-003 SHALL have parameter TIMEOUT, default 500000, max idle clk cycles between bytes inside a frame.
REQ-004 SHALL have port clk  input  1  system clock; all logic on rising edge.
REQ-005 SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-006 SHALL have port rx_data  input  8  byte from UART receiver.
REQ-007 SHALL have port rx_valid  input  1  one-cycle strobe that qualifies rx_data.
REQ-008 SHALL have port out_start  output  1  one-cycle pulse marking the start of a new message to the hash core.
REQ-009 SHALL have port out_data  output  8  payload byte at the FIFO head.
REQ-010 SHALL have port out_valid  output  1  out_data is valid, meaning the FIFO is not empty.
REQ-011 SHALL have port out_last  output  1  head byte is the final payload byte; qualified by out_valid.
REQ-012 SHALL have port out_ready  input  1  downstream accepts the head byte this cycle.
REQ-013 SHALL have port out_abort  output  1  one-cycle pulse meaning the current message is void.
REQ-014 SHALL have port frame_ok  output  1  one-cycle pulse when the checksum matches.
REQ-015 SHALL have port frame_err  output  1  one-cycle pulse on any frame error.
REQ-016 SHALL have port err_code  output  3  error cause, held until the next frame_err or reset.
REQ-017 SHALL have port busy  output  1  high whenever the FSM is not in IDLE.

Function
REQ-018 SHALL accept the frame format: SOF 0x01, LEN_HI, LEN_LO (big-endian), LEN payload bytes, then CHK, where CHK is the XOR of all payload bytes.
REQ-019 SHALL implement FSM states IDLE, LEN_HI, LEN_LO, PAYLOAD and CHECK, with all transitions taken only on rx_valid, except for a timeout.
REQ-020 SHALL handle IDLE as follows: on rx_valid with rx_data==0x01, go to LEN_HI; silently drop any other byte.
REQ-021 SHALL handle LEN_HI as follows: capture len[15:8] and go to LEN_LO.
REQ-022 SHALL handle LEN_LO as follows: capture len[7:0]; if len==0 or len>MAX_LEN, pulse frame_err with err_code=1 and go to IDLE; otherwise load remaining=len, clear chk, pulse out_start in the next cycle, and go to PAYLOAD.
REQ-023 SHALL handle PAYLOAD as follows: on each byte, update chk^=byte, push {byte, remaining==1} into the FIFO, and decrement remaining; go to CHECK when remaining reaches 0.
REQ-024 SHALL accept a FIFO push when the FIFO is not full, or when it is full and a pop occurs in the same cycle.
REQ-025 SHALL treat a push to a full FIFO with no same-cycle pop as overflow: pulse frame_err with err_code=2, pulse out_abort, flush the FIFO, and go to IDLE.
REQ-026 SHALL handle CHECK as follows: on rx_data==chk, pulse frame_ok; otherwise pulse frame_err with err_code=3 and pulse out_abort; go to IDLE in both cases.
REQ-027 SHALL NOT flush the FIFO on a checksum error; already-queued bytes, including the last byte, still drain to downstream.
REQ-028 SHALL count clk cycles since the last rx_valid in LEN_HI, LEN_LO, PAYLOAD and CHECK; when the count reaches TIMEOUT, pulse frame_err with err_code=4 and go to IDLE.
REQ-029 SHALL also pulse out_abort and flush the FIFO on a timeout that occurs in PAYLOAD.
REQ-030 SHALL reset the timeout counter on every rx_valid and hold it at 0 in IDLE.
REQ-031 SHALL pop the FIFO when out_valid && out_ready; out_data and out_last SHALL be driven combinationally from the FIFO head.
REQ-032 SHALL give frame_err precedence over frame_ok, and SHALL never assert both in the same cycle.
REQ-033 SHALL have a minimum latency of 1 cycle from a payload byte's rx_valid to that byte appearing with out_valid.
REQ-034 SHALL use 16-bit len and remaining registers; remaining SHALL never underflow.
REQ-035 SHALL accept a new SOF in IDLE even while the FIFO still holds bytes of the previous frame.

Reset
REQ-036 SHALL, while rst is high, force the FSM to IDLE, empty the FIFO, and clear chk, len, remaining and the timeout counter.
REQ-037 SHALL hold out_start, out_valid, out_last, out_abort, frame_ok, frame_err and busy at 0 during reset, with err_code=0.
REQ-038 SHALL NOT pulse out_abort when rst is asserted mid-frame; reset alone voids the frame.

Verification
REQ-039 SHALL verify a good frame: bytes 01 00 03 61 62 63 60 with out_ready=1 -> out_start once, then 61, 62, 63 with out_last on 63, then frame_ok=1 and err_code unchanged.
REQ-040 SHALL verify a bad checksum: bytes 01 00 01 AA 00 -> AA delivered with out_last, then frame_err=1, err_code=3, out_abort=1.
REQ-041 SHALL verify a bad length: bytes 01 00 00, and separately 01 FF FF -> frame_err with err_code=1, no out_start, no out_valid.
REQ-042 SHALL verify overflow: out_ready=0, FIFO_DEPTH=8, LEN=10, 9 payload bytes -> frame_err with err_code=2 on the 9th byte, out_abort, out_valid=0 afterwards.
REQ-043 SHALL verify a timeout: TIMEOUT=100, bytes 01 00 05 41, then silence -> frame_err with err_code=4 exactly 100 cycles after the 41 strobe, out_abort, busy=0.
REQ-044 SHALL verify noise and reset: bytes 55 02 01 00 02 11 22 33 with rst asserted after 11 -> 55 and 02 ignored, and after reset all outputs are 0 and the FIFO is empty.
